// File: rtl/tag_dispatch.sv
// Tag-routed dispatcher: the tag in the top bits of in_data picks a per-port FIFO
// and is stripped. Out-of-range tags are swallowed and logged in the error registers.
module tag_dispatch #(
  parameter int NUM_OUT    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [TAG_WIDTH+DATA_WIDTH-1:0] in_data,
  output logic [NUM_OUT-1:0]              out_valid,
  input  logic [NUM_OUT-1:0]              out_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0]   out_data,
  output logic                            err_flag,
  output logic [TAG_WIDTH-1:0]            err_tag,
  output logic [7:0]                      err_count,
  input  logic                            err_clear
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_WIDTH-1:0]  tag;
  logic [DATA_WIDTH-1:0] payload;
  logic                  tag_ok;
  logic                  bad_beat;
  logic [NUM_OUT-1:0]    full;
  logic [NUM_OUT-1:0]    push;
  logic [NUM_OUT-1:0]    pop;

  assign tag      = in_data[TAG_WIDTH+DATA_WIDTH-1 -: TAG_WIDTH];
  assign payload  = in_data[DATA_WIDTH-1:0];
  // Widened by one bit so NUM_OUT == 2**TAG_WIDTH still compares correctly.
  assign tag_ok   = {1'b0, tag} < (TAG_WIDTH+1)'(NUM_OUT);
  assign bad_beat = in_valid && !tag_ok;

  // Ready looks only at the addressed FIFO's pre-edge fullness, never at out_ready.
  always_comb begin
    in_ready = 1'b1;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (tag == TAG_WIDTH'(i)) in_ready = !full[i];
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_port
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    assign full[g]      = count == CNT_W'(FIFO_DEPTH);
    assign out_valid[g] = count != '0;
    assign push[g]      = in_valid && in_ready && (tag == TAG_WIDTH'(g));
    assign pop[g]       = out_valid[g] && out_ready[g];
    assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = out_valid[g] ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
      if (push[g]) mem[wr_ptr] <= payload;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push[g]) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop[g])  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push[g], pop[g]})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // A clear in the same cycle as a bad beat wins; that beat is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag  <= 1'b0;
      err_tag   <= '0;
      err_count <= '0;
    end else if (err_clear) begin
      err_flag  <= 1'b0;
      err_tag   <= '0;
      err_count <= '0;
    end else if (bad_beat) begin
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (!err_flag) begin
        err_flag <= 1'b1;
        err_tag  <= tag;
      end
    end
  end

endmodule

// File: tb/tb_tag_dispatch.sv
// Randomized and directed bench for tag_dispatch, checked against per-port queues
// plus a plain error-register model.
module tb_tag_dispatch;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [35:0]  in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [127:0] out_data;
  logic         err_flag;
  logic [3:0]   err_tag;
  logic [7:0]   err_count;
  logic         err_clear;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mq [4][$];
  bit          m_flag;
  logic [3:0]  m_tag;
  int          m_count;

  tag_dispatch #(.NUM_OUT(4), .DATA_WIDTH(32), .TAG_WIDTH(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err_flag(err_flag), .err_tag(err_tag), .err_count(err_count), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  function automatic logic model_ready(logic [35:0] d);
    int t = int'(d[35:32]);
    if (t >= 4) return 1'b1;
    return mq[t].size() < 2;
  endfunction

  function automatic logic [3:0] model_valid();
    logic [3:0] v = '0;
    for (int i = 0; i < 4; i++) v[i] = mq[i].size() != 0;
    return v;
  endfunction

  function automatic logic [127:0] model_data();
    logic [127:0] d = '0;
    for (int i = 0; i < 4; i++) if (mq[i].size() != 0) d[i*32 +: 32] = mq[i][0];
    return d;
  endfunction

  task automatic model_flush();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_flag = 0; m_tag = '0; m_count = 0;
  endtask

  // Advance one clock edge and apply the same transfer to the model, then settle 1 time unit.
  task automatic tick();
    int t;
    logic hs;
    logic [3:0] pops;
    t    = int'(in_data[35:32]);
    hs   = in_valid && model_ready(in_data);
    pops = model_valid() & out_ready;
    @(posedge clk);
    for (int i = 0; i < 4; i++) if (pops[i]) void'(mq[i].pop_front());
    if (hs && t < 4) mq[t].push_back(in_data[31:0]);
    if (err_clear) begin
      m_flag = 0; m_tag = '0; m_count = 0;
    end else if (in_valid && t >= 4) begin
      if (m_count < 255) m_count++;
      if (!m_flag) begin m_flag = 1; m_tag = 4'(t); end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; in_data = '0; out_ready = '0; err_clear = 0;
    model_flush();
    #2;
    n_checks++; if (out_valid !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0000", out_valid); end
    n_checks++; if (out_data !== 128'b0) begin n_fail++; $display("[TB] FAIL reset_data: got %h expected 0", out_data); end
    n_checks++; if ({err_flag, err_tag, err_count} !== 13'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b/%h/%0d expected 0/0/0", err_flag, err_tag, err_count); end
    for (int t = 0; t < 16; t += 5) begin
      in_data = {4'(t), 32'h0};
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready tag %0d: got %b expected 1", t, in_ready); end
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_single();
    out_ready = 4'hF; in_valid = 1; in_data = {4'h2, 32'hDEAD_BEEF};
    #2;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL single_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 0;
    #2;
    n_checks++; if (out_valid !== 4'b0100) begin n_fail++; $display("[TB] FAIL single_valid: got %b expected 0100", out_valid); end
    n_checks++; if (out_data[64 +: 32] !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL single_data: got %h expected deadbeef", out_data[64 +: 32]); end
    tick();
    #2;
    n_checks++; if (out_valid !== 4'b0000) begin n_fail++; $display("[TB] FAIL single_popped: got %b expected 0000", out_valid); end
    n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("[TB] FAIL single_err: got %b expected 0", err_flag); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] got [$];
    out_ready = 4'b1101; in_valid = 1;
    for (int v = 1; v <= 2; v++) begin
      in_data = {4'h1, 32'(v)};
      #2;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_accept %0d: got %b expected 1", v, in_ready); end
      tick();
    end
    in_data = {4'h1, 32'd3};
    #2;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_stall: got %b expected 0", in_ready); end
    tick();
    out_ready = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #2;
      n_checks++; if (in_ready !== model_ready(in_data)) begin n_fail++; $display("[TB] FAIL bp_ready: got %b expected %b", in_ready, model_ready(in_data)); end
      if (out_valid[1]) got.push_back(out_data[32 +: 32]);
      if (in_valid && in_ready) begin tick(); in_valid = 0; end
      else tick();
    end
    n_checks++; if (got.size() != 3) begin n_fail++; $display("[TB] FAIL bp_count: got %0d beats expected 3", got.size()); end
    for (int k = 0; k < got.size() && k < 3; k++) begin
      n_checks++; if (got[k] !== 32'(k + 1)) begin n_fail++; $display("[TB] FAIL bp_order %0d: got %0d expected %0d", k, got[k], k + 1); end
    end
  endtask

  task automatic test_independence();
    out_ready = 4'b1101; in_valid = 1;
    in_data = {4'h1, 32'hA1}; tick();
    in_data = {4'h1, 32'hA2}; tick();
    in_data = {4'h3, 32'h3333};
    #2;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL indep_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 0; out_ready = 4'b0101;
    #2;
    n_checks++; if (out_valid !== 4'b1010) begin n_fail++; $display("[TB] FAIL indep_valid: got %b expected 1010", out_valid); end
    n_checks++; if (out_data[96 +: 32] !== 32'h3333) begin n_fail++; $display("[TB] FAIL indep_p3: got %h expected 3333", out_data[96 +: 32]); end
    n_checks++; if (out_data[32 +: 32] !== 32'hA1) begin n_fail++; $display("[TB] FAIL indep_p1: got %h expected a1", out_data[32 +: 32]); end
    tick();
    out_ready = 4'hF;
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_full_pop();
    logic [31:0] got [$];
    out_ready = 4'b1110; in_valid = 1;
    in_data = {4'h0, 32'd10}; tick();
    in_data = {4'h0, 32'd11}; tick();
    out_ready = 4'hF; in_data = {4'h0, 32'd12};
    #2;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fp_pop_cycle: got %b expected 0", in_ready); end
    if (out_valid[0]) got.push_back(out_data[31:0]);
    tick();
    #2;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fp_next_cycle: got %b expected 1", in_ready); end
    if (out_valid[0]) got.push_back(out_data[31:0]);
    tick();
    in_valid = 0;
    for (int c = 0; c < 4; c++) begin
      #2;
      if (out_valid[0]) got.push_back(out_data[31:0]);
      tick();
    end
    n_checks++; if (got.size() != 3) begin n_fail++; $display("[TB] FAIL fp_count: got %0d beats expected 3", got.size()); end
    for (int k = 0; k < got.size() && k < 3; k++) begin
      n_checks++; if (got[k] !== 32'(10 + k)) begin n_fail++; $display("[TB] FAIL fp_order %0d: got %0d expected %0d", k, got[k], 10 + k); end
    end
  endtask

  task automatic test_errors();
    out_ready = 4'hF; in_valid = 0; err_clear = 1; tick(); err_clear = 0;
    in_valid = 1;
    in_data = {4'h5, 32'h55};
    #2;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL err_ready: got %b expected 1", in_ready); end
    tick();
    in_data = {4'h7, 32'h77}; tick();
    in_valid = 0;
    #2;
    n_checks++; if (out_valid !== 4'b0) begin n_fail++; $display("[TB] FAIL err_no_valid: got %b expected 0000", out_valid); end
    n_checks++; if ({err_flag, err_tag, err_count} !== {1'b1, 4'h5, 8'd2}) begin n_fail++; $display("[TB] FAIL err_regs: got %b/%h/%0d expected 1/5/2", err_flag, err_tag, err_count); end
    in_valid = 1; in_data = {4'h6, 32'h66}; err_clear = 1;
    tick();
    in_valid = 0; err_clear = 0;
    #2;
    n_checks++; if ({err_flag, err_tag, err_count} !== 13'b0) begin n_fail++; $display("[TB] FAIL err_clear: got %b/%h/%0d expected 0/0/0", err_flag, err_tag, err_count); end
  endtask

  task automatic test_saturation();
    in_valid = 1; out_ready = 4'hF;
    in_data = {4'hC, 32'h0}; tick();
    for (int c = 0; c < 260; c++) begin
      in_data = {4'(8 + $urandom_range(0, 7)), 32'($urandom)};
      tick();
    end
    in_valid = 0;
    #2;
    n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_count: got %0d expected 255", err_count); end
    n_checks++; if (err_tag !== 4'hC) begin n_fail++; $display("[TB] FAIL sat_tag: got %h expected c", err_tag); end
    err_clear = 1; tick(); err_clear = 0;
  endtask

  task automatic test_async_reset();
    out_ready = 4'b1011; in_valid = 1;
    in_data = {4'h2, 32'h21}; tick();
    in_data = {4'h2, 32'h22}; tick();
    in_data = {4'h9, 32'h99}; tick();
    in_valid = 0;
    #2;
    n_checks++; if (out_valid[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_before: got %b expected 1", out_valid[2]); end
    rst = 1;
    #1;
    model_flush();
    n_checks++; if (out_valid !== 4'b0) begin n_fail++; $display("[TB] FAIL ar_valid: got %b expected 0000", out_valid); end
    n_checks++; if (out_data !== 128'b0) begin n_fail++; $display("[TB] FAIL ar_data: got %h expected 0", out_data); end
    @(posedge clk); #1;
    rst = 0; out_ready = 4'hF;
    for (int c = 0; c < 4; c++) begin
      #2;
      n_checks++; if (out_valid !== 4'b0 || err_count !== 8'd0) begin n_fail++; $display("[TB] FAIL ar_after: got %b/%0d expected 0000/0", out_valid, err_count); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int t;
      t = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = {4'(t), 32'($urandom)};
      out_ready = 4'($urandom);
      err_clear = $urandom_range(0, 29) == 0;
      #2;
      n_checks++; if (in_ready !== model_ready(in_data)) begin n_fail++; $display("[TB] FAIL rnd_ready cyc %0d: got %b expected %b", c, in_ready, model_ready(in_data)); end
      n_checks++; if (out_valid !== model_valid()) begin n_fail++; $display("[TB] FAIL rnd_valid cyc %0d: got %b expected %b", c, out_valid, model_valid()); end
      n_checks++; if (out_data !== model_data()) begin n_fail++; $display("[TB] FAIL rnd_data cyc %0d: got %h expected %h", c, out_data, model_data()); end
      n_checks++; if ({err_flag, err_tag, err_count} !== {m_flag, m_tag, 8'(m_count)}) begin n_fail++; $display("[TB] FAIL rnd_err cyc %0d: got %b/%h/%0d expected %b/%h/%0d", c, err_flag, err_tag, err_count, m_flag, m_tag, m_count); end
      tick();
    end
    in_valid = 0; err_clear = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_independence();
    test_full_pop();
    test_errors();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_dispatch.md
# tag_dispatch

Tag-routed dispatcher that shares one tagged input stream among NUM_OUT untagged consumers. The tag field selects the destination port and is stripped on the way out, exactly as a per-port tag removal would. Each destination has its own small FIFO so that a stalled consumer blocks only its own traffic. The block sits after a tagged merge point and in front of per-lane compute units. Out-of-range tags are consumed, dropped and reported.

## Interface
- NUM_OUT, 4: number of destination ports; range 2..16; must satisfy NUM_OUT <= 2**TAG_WIDTH.
- DATA_WIDTH, 32: payload width.
- TAG_WIDTH, 4: tag width; the tag occupies the MSBs of in_data.
- FIFO_DEPTH, 2: entries per destination FIFO; power of two, >= 2.

Ports (clock and reset first):
- clk  input  1  single clock; all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  TAG_WIDTH+DATA_WIDTH  {tag, payload}.
- out_valid  output  NUM_OUT  per-port valid.
- out_ready  input  NUM_OUT  per-port ready.
- out_data  output  NUM_OUT*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- err_flag  output  1  sticky; set on the first out-of-range tag.
- err_tag  output  TAG_WIDTH  tag of the first dropped beat since the last clear.
- err_count  output  8  dropped-beat counter; saturates at 255.
- err_clear  input  1  synchronous clear of err_flag, err_tag and err_count.

## Operation
- tag = in_data[TAG_WIDTH+DATA_WIDTH-1 -: TAG_WIDTH]; payload = in_data[DATA_WIDTH-1:0].
- Valid tag (tag < NUM_OUT):
  - in_ready = !full[tag].
  - On handshake, the payload is written at FIFO[tag] wr_ptr.
  - in_ready depends on in_data and FIFO state only; never on in_valid or out_ready.
- Invalid tag (tag >= NUM_OUT):
  - in_ready = 1; the beat is consumed and discarded.
  - err_count increments, saturating at 255.
  - If err_flag was 0: err_flag <= 1 and err_tag <= tag.
  - Later bad tags do not overwrite err_tag.
- err_clear has priority over a same-cycle error: after the edge, err_flag = 0, err_tag = 0, err_count = 0, and the concurrent bad beat is not counted.
- Each FIFO has:
  - pointers of width log2(FIFO_DEPTH) that wrap modulo FIFO_DEPTH;
  - an occupancy count of width log2(FIFO_DEPTH)+1;
  - full when count == FIFO_DEPTH, empty when count == 0.
- out_valid[i] = !empty[i]; out_data[i] = head entry of FIFO i. Stable while out_valid && !out_ready.
- Pop on out_valid[i] && out_ready[i].
- Simultaneous push and pop on the same FIFO: count is unchanged and both pointers advance.
- A full FIFO does not accept a push in the same cycle as a pop; in_ready stays 0 that cycle. There is no combinational path from out_ready to in_ready.
- Ports are independent; one port stalled full never blocks beats tagged for another port.
- Ordering is preserved per port. No ordering guarantee holds across ports.

## Timing
- Reset (asynchronous assert, released on clock): all FIFOs empty, pointers 0.
  - Reset output values: out_valid = 0, out_data = 0, err_flag = 0, err_tag = 0, err_count = 0.
  - in_ready during and after reset follows the combinational rule: 1 for any tag, since all FIFOs are empty.
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N. No combinational input-to-output path.
- Throughput: 1 beat/cycle into any non-full port. With FIFO_DEPTH >= 2 and out_ready held at 1, a port sustains 1 beat/cycle indefinitely.
- Reset asserted mid-operation: FIFO contents are discarded immediately and out_valid drops asynchronously. No beat is emitted after reset release until a new beat is accepted.
- Error outputs update at the edge after the bad handshake.

## Test plan
- Reset, then send {4'h2, 32'hDEAD_BEEF} with all out_ready=1 -> out_valid = 4'b0100 the next cycle, port 2 data = DEAD_BEEF, popped after one cycle, err_flag = 0.
- out_ready[1]=0, send 3 beats tagged 1 (values 1, 2, 3) -> first two accepted; in_ready=0 on the third. Raise out_ready[1] -> port 1 emits 1, 2, then 3, in order.
- Port 1 held full, then send a beat tagged 3 -> in_ready=1 immediately, port 3 emits it next cycle, port 1 unchanged.
- Port 0 full with out_ready[0]=1 and a beat tagged 0 pending -> in_ready=0 in the pop cycle, accepted the following cycle. No loss and no duplication.
- Send tags 5 then 7 with NUM_OUT=4 -> both consumed, no out_valid, err_flag=1, err_tag=5, err_count=2. Assert err_clear with a concurrent tag 6 -> all error outputs 0.
- Assert rst with 2 beats queued on port 2 -> out_valid=0 immediately. After release, no beat is emitted and err_count = 0.
